// File: rtl/fifo_ext_pkg.sv
// Shared helpers for fifo_ext: count-width calculation and parameter legality checks.
package fifo_ext_pkg;

    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    function automatic bit depth_ok(input int unsigned depth);
        return depth >= 2;
    endfunction

    function automatic bit af_thr_ok(input int unsigned thr, input int unsigned depth);
        return (thr >= 1) && (thr <= depth);
    endfunction

    function automatic bit ae_thr_ok(input int unsigned thr, input int unsigned depth);
        return thr <= depth - 1;
    endfunction

endpackage

// File: rtl/fifo_ext_if.sv
// Handshake, data and status bundle between fifo_ext and its producer/consumer.
interface fifo_ext_if #(
    parameter int unsigned DataWidth = 8,
    parameter int unsigned CntWidth  = 5
);
    logic                 i_flush;
    logic                 i_err_clr;
    logic                 i_wr_en;
    logic [DataWidth-1:0] i_wr_data;
    logic                 i_rd_en;
    logic [DataWidth-1:0] o_rd_data;
    logic                 o_rd_valid;
    logic                 o_full;
    logic                 o_empty;
    logic                 o_almost_full;
    logic                 o_almost_empty;
    logic [CntWidth-1:0]  o_count;
    logic                 o_overflow;
    logic                 o_underflow;

    modport master (
        output i_flush, i_err_clr, i_wr_en, i_wr_data, i_rd_en,
        input  o_rd_data, o_rd_valid, o_full, o_empty, o_almost_full,
               o_almost_empty, o_count, o_overflow, o_underflow
    );

    modport slave (
        input  i_flush, i_err_clr, i_wr_en, i_wr_data, i_rd_en,
        output o_rd_data, o_rd_valid, o_full, o_empty, o_almost_full,
               o_almost_empty, o_count, o_overflow, o_underflow
    );
endinterface

// File: rtl/fifo_ext_ptr.sv
// Pointer register counting 0..Depth-1 with an explicit wrap, so non-power-of-two depths work.
module fifo_ext_ptr #(
    parameter int unsigned Depth    = 16,
    parameter int unsigned PtrWidth = (Depth > 1) ? $clog2(Depth) : 1
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_clr,
    input  logic                i_inc,
    output logic [PtrWidth-1:0] o_ptr
);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clr) begin
            o_ptr <= '0;
        end else if (i_inc) begin
            o_ptr <= (o_ptr == PtrWidth'(Depth - 1)) ? '0 : o_ptr + 1'b1;
        end
    end

endmodule

// File: rtl/fifo_ext.sv
// Synchronous FIFO with arbitrary depth, fill level, thresholds, sticky errors,
// flush and selectable fall-through or registered read.
module fifo_ext
    import fifo_ext_pkg::*;
#(
    parameter int unsigned DataWidth      = 8,
    parameter int unsigned Depth          = 16,
    parameter bit          FWFT           = 1'b1,
    parameter int unsigned AlmostFullThr  = Depth - 2,
    parameter int unsigned AlmostEmptyThr = 2
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    fifo_ext_if.slave  bus
);

    localparam int unsigned CntWidth = cnt_width(Depth);
    localparam int unsigned PtrWidth = $clog2(Depth);

    if (!depth_ok(Depth)) begin : g_bad_depth
        $error("fifo_ext: Depth must be at least 2");
    end
    if (!af_thr_ok(AlmostFullThr, Depth)) begin : g_bad_af
        $error("fifo_ext: AlmostFullThr must be in 1..Depth");
    end
    if (!ae_thr_ok(AlmostEmptyThr, Depth)) begin : g_bad_ae
        $error("fifo_ext: AlmostEmptyThr must be in 0..Depth-1");
    end

    logic [DataWidth-1:0] mem [Depth];
    logic [PtrWidth-1:0]  wr_ptr;
    logic [PtrWidth-1:0]  rd_ptr;
    logic [CntWidth-1:0]  count_q;
    logic [CntWidth-1:0]  count_nxt;
    logic                 full_q, empty_q, afull_q, aempty_q;
    logic                 ovf_q, unf_q;
    logic                 rd_acc, wr_acc, ovf_set, unf_set;

    // Flush masks both requests, so nothing moves and no error is raised that cycle.
    always_comb begin
        rd_acc  = bus.i_rd_en && !empty_q && !bus.i_flush;
        wr_acc  = bus.i_wr_en && (!full_q || rd_acc) && !bus.i_flush;
        ovf_set = bus.i_wr_en && !wr_acc && !bus.i_flush;
        unf_set = bus.i_rd_en && !rd_acc && !bus.i_flush;
        count_nxt = count_q;
        if (bus.i_flush) begin
            count_nxt = '0;
        end else if (wr_acc && !rd_acc) begin
            count_nxt = count_q + 1'b1;
        end else if (rd_acc && !wr_acc) begin
            count_nxt = count_q - 1'b1;
        end
    end

    fifo_ext_ptr #(.Depth(Depth), .PtrWidth(PtrWidth)) u_wr_ptr (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (bus.i_flush),
        .i_inc   (wr_acc),
        .o_ptr   (wr_ptr)
    );

    fifo_ext_ptr #(.Depth(Depth), .PtrWidth(PtrWidth)) u_rd_ptr (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_clr   (bus.i_flush),
        .i_inc   (rd_acc),
        .o_ptr   (rd_ptr)
    );

    always_ff @(posedge i_clk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= bus.i_wr_data;
        end
    end

    // Flags decode the next count so they always agree with o_count.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            count_q  <= '0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            afull_q  <= 1'b0;
            aempty_q <= 1'b1;
            ovf_q    <= 1'b0;
            unf_q    <= 1'b0;
        end else begin
            count_q  <= count_nxt;
            full_q   <= (count_nxt == CntWidth'(Depth));
            empty_q  <= (count_nxt == '0);
            afull_q  <= (count_nxt >= CntWidth'(AlmostFullThr));
            aempty_q <= (count_nxt <= CntWidth'(AlmostEmptyThr));
            ovf_q    <= ovf_set || (ovf_q && !bus.i_err_clr);
            unf_q    <= unf_set || (unf_q && !bus.i_err_clr);
        end
    end

    if (FWFT) begin : g_fwft
        assign bus.o_rd_data  = mem[rd_ptr];
        assign bus.o_rd_valid = !empty_q;
    end else begin : g_reg
        logic [DataWidth-1:0] rd_data_q;
        logic                 rd_valid_q;

        always_ff @(posedge i_clk) begin
            if (!i_rst_n) begin
                rd_data_q  <= '0;
                rd_valid_q <= 1'b0;
            end else begin
                rd_valid_q <= rd_acc;
                if (rd_acc) begin
                    rd_data_q <= mem[rd_ptr];
                end
            end
        end

        assign bus.o_rd_data  = rd_data_q;
        assign bus.o_rd_valid = rd_valid_q;
    end

    assign bus.o_count        = count_q;
    assign bus.o_full         = full_q;
    assign bus.o_empty        = empty_q;
    assign bus.o_almost_full  = afull_q;
    assign bus.o_almost_empty = aempty_q;
    assign bus.o_overflow     = ovf_q;
    assign bus.o_underflow    = unf_q;

endmodule

// File: tb/tb_fifo_ext.sv
// Scoreboard bench: one FWFT and one registered-read fifo_ext (Depth=5) driven in lockstep.
module tb_fifo_ext;
    import fifo_ext_pkg::*;

    localparam int unsigned D   = 5;
    localparam int unsigned CW  = cnt_width(D);
    localparam int unsigned AF  = 4;
    localparam int unsigned AE  = 1;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush, err_clr, wr_en, rd_en;
    logic [7:0] wr_data;

    fifo_ext_if #(.DataWidth(8), .CntWidth(CW)) bus1 ();
    fifo_ext_if #(.DataWidth(8), .CntWidth(CW)) bus0 ();

    assign bus1.i_flush   = flush;
    assign bus1.i_err_clr = err_clr;
    assign bus1.i_wr_en   = wr_en;
    assign bus1.i_wr_data = wr_data;
    assign bus1.i_rd_en   = rd_en;
    assign bus0.i_flush   = flush;
    assign bus0.i_err_clr = err_clr;
    assign bus0.i_wr_en   = wr_en;
    assign bus0.i_wr_data = wr_data;
    assign bus0.i_rd_en   = rd_en;

    fifo_ext #(.DataWidth(8), .Depth(D), .FWFT(1'b1),
               .AlmostFullThr(AF), .AlmostEmptyThr(AE)) u_dut1 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus1)
    );

    fifo_ext #(.DataWidth(8), .Depth(D), .FWFT(1'b0),
               .AlmostFullThr(AF), .AlmostEmptyThr(AE)) u_dut0 (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus0)
    );

    always #5 clk = ~clk;

    int unsigned n_chk = 0;
    int unsigned n_bad = 0;

    logic [7:0] sb_q [$];
    bit         m_ovf, m_unf, m_rv0;
    logic [7:0] m_rd0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input bit w, input logic [7:0] d, input bit r,
                        input bit fl = 1'b0, input bit clr = 1'b0, input bit rst = 1'b0);
        bit         ra, wa;
        logic [7:0] head;
        int unsigned n;
        wr_en = w; wr_data = d; rd_en = r; flush = fl; err_clr = clr; rst_n = !rst;
        #1;
        ra = !rst && !fl && r && (sb_q.size() > 0);
        wa = !rst && !fl && w && ((sb_q.size() < D) || ra);
        if (ra) begin
            head = sb_q.pop_front();
            check("fwft_pop_data", bus1.o_rd_data, head);
            m_rd0 = head;
        end
        if (wa) sb_q.push_back(d);
        if (rst) begin
            sb_q.delete();
            m_ovf = 1'b0; m_unf = 1'b0; m_rv0 = 1'b0; m_rd0 = '0;
        end else if (fl) begin
            sb_q.delete();
            m_ovf = m_ovf && !clr; m_unf = m_unf && !clr; m_rv0 = 1'b0;
        end else begin
            m_ovf = (w && !wa) || (m_ovf && !clr);
            m_unf = (r && !ra) || (m_unf && !clr);
            m_rv0 = ra;
        end
        @(posedge clk);
        #1;
        n = sb_q.size();
        check("count1",     bus1.o_count, n);
        check("count0",     bus0.o_count, n);
        check("full",       bus1.o_full, n == D);
        check("empty",      bus1.o_empty, n == 0);
        check("almost_full", bus1.o_almost_full, n >= AF);
        check("almost_empty", bus1.o_almost_empty, n <= AE);
        check("flags0",     {bus0.o_full, bus0.o_empty, bus0.o_almost_full, bus0.o_almost_empty},
                            {n == D, n == 0, n >= AF, n <= AE});
        check("overflow",   bus1.o_overflow, m_ovf);
        check("underflow",  bus1.o_underflow, m_unf);
        check("errs0",      {bus0.o_overflow, bus0.o_underflow}, {m_ovf, m_unf});
        check("rd_valid1",  bus1.o_rd_valid, n != 0);
        check("rd_valid0",  bus0.o_rd_valid, m_rv0);
        check("rd_data0",   bus0.o_rd_data, m_rd0);
        if (n != 0) check("fwft_head", bus1.o_rd_data, sb_q[0]);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; err_clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0; wr_data = '0;
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0);

        // fill to full, then one overflowing write
        for (int i = 0; i < 5; i++) step(1, 8'h11 + 8'(i), 0);
        step(1, 8'h16, 0);
        step(0, 0, 0, 0, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 1);
        step(0, 0, 1);
        step(0, 0, 0, 0, 1);

        // alternating write/read across pointer wrap
        for (int i = 0; i < 12; i++) begin
            step(1, 8'h40 + 8'(i), 0);
            step(0, 0, 1);
        end

        // full plus simultaneous write/read, drain, empty plus simultaneous write/read
        for (int i = 0; i < 5; i++) step(1, 8'h60 + 8'(i), 0);
        step(1, 8'hAA, 1);
        for (int i = 0; i < 5; i++) step(0, 0, 1);
        step(1, 8'h77, 1);
        step(0, 0, 1, 0, 1);

        // registered read of a single word then hold
        step(1, 8'h3C, 0);
        step(0, 0, 1);
        step(0, 0, 0);
        step(0, 0, 0);

        // flush at count 3 with a write pending
        for (int i = 0; i < 3; i++) step(1, 8'h80 + 8'(i), 0);
        step(1, 8'h99, 1, 1);
        step(0, 0, 0);

        // random traffic with occasional flush and error clear
        for (int i = 0; i < 300; i++) begin
            step(bit'($urandom_range(0, 1)), 8'($urandom), bit'($urandom_range(0, 1)),
                 $urandom_range(0, 29) == 0, $urandom_range(0, 9) == 0);
        end

        // reset mid-stream
        for (int i = 0; i < 3; i++) step(1, 8'hC0 + 8'(i), 0);
        step(0, 0, 1);
        step(1, 8'hEE, 1, 0, 0, 1);
        step(0, 0, 0);
        step(1, 8'h5A, 0);
        step(0, 0, 1);
        step(0, 0, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
